// File: rtl/turn_seq_pkg.sv
// Shared constants and helpers for the turn sequencer.
package turn_seq_pkg;

  localparam int MOVE_W        = 8;
  localparam int N_PLAYERS_DEF = 2;
  localparam int MAX_MOVES_DEF = 9;

  // Width of a player index; at least one bit even for tiny player counts.
  function automatic int calc_pw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turn_sequencer_rr_next_active.sv
// Round-robin search for the next active player after the current index.
// Purely combinational; shared by the load path and the advance path.
module rr_next_active
  import turn_seq_pkg::*;
#(
  parameter int N_PLAYERS = N_PLAYERS_DEF,
  parameter int PW        = calc_pw(N_PLAYERS)
) (
  input  logic [PW-1:0]        cur,
  input  logic [N_PLAYERS-1:0] mask,
  output logic [PW-1:0]        nxt,
  output logic                 found
);

  logic hit;
  int   j;

  // Scan cur+1 .. cur+N-1 (mod N); fall back to cur itself when nothing else is active.
  always_comb begin
    nxt = cur;
    hit = 1'b0;
    j   = 0;
    for (int k = 1; k < N_PLAYERS; k++) begin
      j = (int'(cur) + k) % N_PLAYERS;
      if (!hit && mask[j]) begin
        hit = 1'b1;
        nxt = PW'(j);
      end
    end
    found = hit | mask[cur];
  end

endmodule

// File: rtl/turn_sequencer.sv
// Round-robin turn sequencer with inactive-player skipping, move counting
// and game-over detection.
// Optional idle timeout forcing an advance: define TURN_SEQ_TIMEOUT_EN.
module turn_sequencer
  import turn_seq_pkg::*;
#(
  parameter int N_PLAYERS      = N_PLAYERS_DEF,
  parameter int MAX_MOVES      = MAX_MOVES_DEF,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PW             = calc_pw(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 load,
  input  logic [PW-1:0]        start_player,
  input  logic                 advance,
  input  logic [N_PLAYERS-1:0] active_mask,
  output logic [PW-1:0]        player_idx,
  output logic [N_PLAYERS-1:0] player_onehot,
  output logic [MOVE_W-1:0]    move_count,
  output logic                 game_over,
  output logic                 round_wrap,
  output logic                 no_player,
  output logic                 timeout
);

  logic [PW-1:0] start_s;
  logic [PW-1:0] load_nxt;
  logic [PW-1:0] adv_nxt;
  logic [PW-1:0] load_idx;
  logic          load_found;
  logic          adv_found;
  logic          adv_ok;
  logic          step;

  assign no_player = ~|active_mask;
  assign adv_ok    = advance & ~game_over & ~no_player;

  // Out-of-range start indices fold to player 0.
  assign start_s  = (int'(start_player) < N_PLAYERS) ? start_player : '0;
  assign load_idx = active_mask[start_s] ? start_s : load_nxt;

  rr_next_active #(.N_PLAYERS(N_PLAYERS), .PW(PW)) u_next_load (
    .cur   (start_s),
    .mask  (active_mask),
    .nxt   (load_nxt),
    .found (load_found)
  );

  rr_next_active #(.N_PLAYERS(N_PLAYERS), .PW(PW)) u_next_adv (
    .cur   (player_idx),
    .mask  (active_mask),
    .nxt   (adv_nxt),
    .found (adv_found)
  );

  // Found flags are implied by no_player here; kept for the shared interface.
  logic unused_found;
  assign unused_found = load_found ^ adv_found;

`ifdef TURN_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        fire;

  assign fire = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) & ~game_over & ~no_player;
  assign step = adv_ok | fire;

  // Idle counter: restarts on any new game or accepted move, frozen while play is stalled.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= fire & ~advance & ~load;
      if (load || step) tmo_cnt <= '0;
      else if (!game_over && !no_player) tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = |32'(TIMEOUT_CYCLES);
  assign step       = adv_ok;
  assign timeout    = 1'b0;
`endif

  // Turn state: load beats advance beats hold; round_wrap is a one-cycle pulse.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      player_idx <= '0;
      move_count <= '0;
      game_over  <= 1'b0;
      round_wrap <= 1'b0;
    end else begin
      round_wrap <= 1'b0;
      if (load) begin
        player_idx <= load_idx;
        move_count <= '0;
        game_over  <= 1'b0;
      end else if (step) begin
        player_idx <= adv_nxt;
        move_count <= move_count + MOVE_W'(1);
        game_over  <= ((move_count + MOVE_W'(1)) == MOVE_W'(MAX_MOVES));
        round_wrap <= (adv_nxt <= player_idx);
      end
    end
  end

  // One-hot view of the current player, blanked when nobody is active.
  always_comb begin
    player_onehot = '0;
    if (!no_player) player_onehot[player_idx] = 1'b1;
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Randomized bench for turn_sequencer (N_PLAYERS=5, MAX_MOVES=9, TIMEOUT_CYCLES=5)
// against a behavioural model of the turn rules.
module tb_turn_sequencer;

  localparam int N    = 5;
  localparam int MAXM = 9;
  localparam int TMO  = 5;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       load = 1'b0;
  logic [2:0] start_player = '0;
  logic       advance = 1'b0;
  logic [4:0] active_mask = '1;
  logic [2:0] player_idx;
  logic [4:0] player_onehot;
  logic [7:0] move_count;
  logic       game_over;
  logic       round_wrap;
  logic       no_player;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_idx = 0;
  int m_cnt = 0;
  bit m_go  = 0;
  bit m_wrap = 0;
  bit m_tmo = 0;
  int m_tc  = 0;

  turn_sequencer #(.N_PLAYERS(N), .MAX_MOVES(MAXM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .clear         (clear),
    .load          (load),
    .start_player  (start_player),
    .advance       (advance),
    .active_mask   (active_mask),
    .player_idx    (player_idx),
    .player_onehot (player_onehot),
    .move_count    (move_count),
    .game_over     (game_over),
    .round_wrap    (round_wrap),
    .no_player     (no_player),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next active player after x in round-robin order, x itself if nobody else is.
  function automatic int mnext(input int x, input logic [4:0] m);
    for (int k = 1; k < N; k++) begin
      int j;
      j = (x + k) % N;
      if (m[j]) return j;
    end
    return x;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_idx"},  32'(player_idx), 32'(m_idx));
    check({tag, "_cnt"},  32'(move_count), 32'(m_cnt));
    check({tag, "_go"},   32'(game_over),  32'(m_go));
    check({tag, "_wrap"}, 32'(round_wrap), 32'(m_wrap));
    check({tag, "_tmo"},  32'(timeout),    32'(m_tmo));
  endtask

  // Apply one cycle of inputs, predict, clock, compare.
  task automatic run_cycle(input bit ld, input bit adv, input logic [2:0] sp, input logic [4:0] mk);
    int  s, n, ni, nc, ntc;
    bit  ng, nw, nt, np, fire, stepped;
    load = ld; advance = adv; start_player = sp; active_mask = mk;
    #2;
    np = (mk == 5'd0);
    check("no_player", 32'(no_player), 32'(np));
    check("onehot", 32'(player_onehot), np ? 32'd0 : (32'd1 << m_idx));
    ni = m_idx; nc = m_cnt; ng = m_go; nw = 0; nt = 0; ntc = m_tc; stepped = 0;
    fire = 0;
`ifdef TURN_SEQ_TIMEOUT_EN
    fire = (m_tc == TMO - 1) && !m_go && !np;
`endif
    if (ld) begin
      s  = (int'(sp) < N) ? int'(sp) : 0;
      ni = mk[s] ? s : mnext(s, mk);
      nc = 0; ng = 0;
    end else if ((adv && !m_go && !np) || fire) begin
      n  = mnext(m_idx, mk);
      nw = (n <= m_idx);
      ni = n; nc = m_cnt + 1; ng = (nc == MAXM);
      stepped = 1;
      nt = fire && !adv;
    end
    if (ld || stepped) ntc = 0;
    else if (!m_go && !np) ntc = m_tc + 1;
    @(posedge clk); #1;
    m_idx = ni; m_cnt = nc; m_go = ng; m_wrap = nw; m_tmo = nt; m_tc = ntc;
    check_state("cyc");
  endtask

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_go = 0; m_wrap = 0; m_tmo = 0; m_tc = 0;
  endtask

  // Pulse clear between clock edges and verify the outputs drop without a clock.
  task automatic async_clear();
    #2 clear = 1'b1;
    #1;
    model_reset();
    check_state("aclr");
    #1 clear = 1'b0;
  endtask

  initial begin
    // Reset
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    check_state("reset");

    // Two active players toggle: 1, 0, 1 with a wrap on the return to 0
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 3'd0, 5'b00011);
    check("t1_idx", 32'(player_idx), 32'd1);
    check("t1_cnt", 32'(move_count), 32'd3);

    // Skip inactive: mask bits 0,1,3; start at inactive 2 lands on 3
    run_cycle(1, 0, 3'd2, 5'b01011);
    check("t2_load", 32'(player_idx), 32'd3);
    run_cycle(0, 1, 3'd0, 5'b01011);
    check("t2_a1", 32'(player_idx), 32'd0);
    check("t2_wrap", 32'(round_wrap), 32'd1);
    run_cycle(0, 1, 3'd0, 5'b01011);
    run_cycle(0, 1, 3'd0, 5'b01011);
    check("t2_a3", 32'(player_idx), 32'd3);

    // Game over after 9 moves, then frozen; load clears it
    run_cycle(1, 0, 3'd0, 5'b11111);
    for (int i = 0; i < 12; i++) run_cycle(0, 1, 3'd0, 5'b11111);
    check("t3_cnt", 32'(move_count), 32'd9);
    check("t3_go", 32'(game_over), 32'd1);
    run_cycle(1, 0, 3'd0, 5'b11111);
    check("t3_go_clr", 32'(game_over), 32'd0);

    // Load wins over a simultaneous advance
    run_cycle(0, 1, 3'd0, 5'b11111);
    run_cycle(0, 1, 3'd0, 5'b11111);
    run_cycle(1, 1, 3'd1, 5'b11111);
    check("t4_idx", 32'(player_idx), 32'd1);
    check("t4_cnt", 32'(move_count), 32'd0);

    // Out-of-range start folds to 0; single active player wraps every move
    run_cycle(1, 0, 3'd6, 5'b11111);
    check("t4b_idx", 32'(player_idx), 32'd0);
    run_cycle(0, 1, 3'd0, 5'b00100);
    run_cycle(0, 1, 3'd0, 5'b00100);
    check("t4c_wrap", 32'(round_wrap), 32'd1);

    // Empty mask stalls play; restoring it resumes
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 3'd0, 5'b00000);
    run_cycle(0, 1, 3'd0, 5'b10001);
    async_clear();

    // Idle stretch (forces an advance when the timeout feature is built)
    run_cycle(1, 0, 3'd0, 5'b11111);
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 3'd0, 5'b11111);
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 3'd0, 5'b11111);
    run_cycle(0, 1, 3'd0, 5'b11111);

    // Randomized play
    for (int i = 0; i < 600; i++) begin
      bit ld, adv;
      logic [4:0] mk;
      if ($urandom_range(0, 99) == 0) async_clear();
      ld  = ($urandom_range(0, 15) == 0);
      adv = ($urandom_range(0, 2) == 0);
      mk  = ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom);
      run_cycle(ld, adv, 3'($urandom), mk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised successor to the two-player alternating flip-flop.
- Sequences turns among N_PLAYERS players in round-robin order. Players marked inactive are skipped.
- Counts moves and flags game-over once MAX_MOVES is reached.
- Sits between the game-control FSM, which issues `advance` and `load`, and the board/display logic, which consumes the current player.

Parameters:
- N_PLAYERS, 2, number of players; legal range 2..16.
- MAX_MOVES, 9, moves before game_over asserts; legal range 1..255.
- TIMEOUT_CYCLES, 1000, idle cycles before a forced advance; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- load  in  1  start a new game at start_player.
- start_player  in  PW=max(1,$clog2(N_PLAYERS))  first player for the new game.
- advance  in  1  end the current turn; one pulse per move.
- active_mask  in  N_PLAYERS  bit i set means player i takes turns.
- player_idx  out  PW  registered index of the current player.
- player_onehot  out  N_PLAYERS  one-hot decode of player_idx; all zeros when no_player is high.
- move_count  out  8  moves completed since load or reset.
- game_over  out  1  high once move_count reaches MAX_MOVES.
- round_wrap  out  1  one-cycle pulse when a turn passes wrap back to the same or a lower index.
- no_player  out  1  combinational, high when active_mask is all zeros.
- timeout  out  1  one-cycle pulse on a forced advance.

Behaviour:
- **Reset (clear=1, asynchronous):**
  - player_idx=0, move_count=0.
  - game_over=0, round_wrap=0, timeout=0.
  - Timeout counter=0.
  - A reset mid-game abandons the game immediately.
- **next(x):** the first index j in x+1, x+2, …, x+N_PLAYERS-1 (mod N_PLAYERS) with active_mask[j]=1.
  - If none is found and active_mask[x]=1, next(x)=x.
  - active_mask is sampled in the same cycle it is used.
- **Priority each cycle: load > advance > hold.**
- **load=1:**
  - player_idx <= start_player if that player is active, otherwise next(start_player).
  - move_count <= 0, game_over <= 0.
  - round_wrap stays low.
  - Any advance in the same cycle is ignored.
  - start_player >= N_PLAYERS is treated as 0.
- **advance=1, with game_over=0 and no_player=0:**
  - player_idx <= next(player_idx).
  - move_count <= move_count+1.
  - game_over <= 1 when move_count+1 == MAX_MOVES.
  - round_wrap pulses in the following cycle when next(player_idx) <= player_idx. A single active player therefore pulses round_wrap on every move.
- **advance ignored** when game_over=1 or no_player=1. State holds and no pulses are produced.
- **Inactive current player:** if the current player is deactivated mid-turn, it keeps the turn until the next advance. move_count never wraps because game_over freezes it.
- **Latency:** all state outputs update on the clock edge after the triggering input. There are no combinational paths from advance to player_idx.
- **Default configuration:** N_PLAYERS=2 with both players active reproduces toggle behaviour.

Optional Feature:
- **Macro:** TURN_SEQ_TIMEOUT_EN.
- **Defined:**
  - A counter increments every cycle while game_over=0 and no_player=0.
  - The counter clears on load or on any accepted advance.
  - When it reaches TIMEOUT_CYCLES-1, the block performs an internal advance with all the rules above and pulses timeout for one cycle.
  - An external advance in the same cycle produces only one advance, and timeout stays low.
- **Undefined:** no counter is built, timeout is tied to 0, and the port list is unchanged.

Decomposition:
- **Package turn_seq_pkg:**
  - Constants MOVE_W=8, default N_PLAYERS and default MAX_MOVES.
  - A function computing PW.
- **Sub-module rr_next_active:** purely combinational, parametrised by N_PLAYERS.
  - Inputs: current index and mask.
  - Outputs: next index and a found flag.
  - Reused for both the load path and the advance path.

Test Plan:
1. **Two-player toggle.** N=2, mask=2'b11, reset, then advance x3 → player_idx 1, 0, 1; round_wrap pulses after the second advance; move_count=3.
2. **Skip inactive.** N=4, mask=4'b1011, load start_player=2 → player_idx=3. Advance x3 → 0, 1, 3, with round_wrap after the move to 0.
3. **Game over.** N=2, MAX_MOVES=9, advance x12 → move_count stops at 9 and game_over=1 after the 9th advance; player_idx is frozen from then on. A subsequent load clears game_over.
4. **Load vs advance collision.** Mid-game, load=1 and advance=1 in the same cycle with start_player=1 → player_idx=1, move_count=0.
5. **Empty mask and asynchronous reset.** mask=0 → no_player=1 and advances are ignored. Restoring the mask lets play resume. Asserting clear between clock edges zeroes the outputs immediately.
6. **Timeout (TURN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=5).** No advance for 5 cycles → timeout pulses and player_idx advances. An external advance on the expiry cycle → a single advance with timeout=0.
